// File: rtl/baud_pkg.sv
`timescale 1ns/1ps
// Shared constants and helpers for the fractional baud-rate generator.
package baud_pkg;

    localparam int unsigned DIV_MIN      = 2;
    localparam int unsigned DEFAULT_INT  = 162;
    localparam int unsigned DEFAULT_FRAC = 12;

    // Bits needed to count 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/baud_ovs_counter.sv
`timescale 1ns/1ps
// Mod-OVS sample-tick counter; o_wrap flags the enabled step from OVS-1 back to 0.
module baud_ovs_counter
    import baud_pkg::*;
#(
    parameter int unsigned OVS = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_wrap
);

    localparam int unsigned CNT_W = clog2(OVS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVS - 1);

    logic [CNT_W-1:0] cnt_q;

    assign o_wrap = i_enable && (cnt_q == LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_enable) begin
            cnt_q <= o_wrap ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/baud_rate_generator_frac.sv
`timescale 1ns/1ps
// Fractional clock divider producing oversampling and bit ticks for the UART path,
// with a load/ack handshake that swaps the divisor only at a period boundary.
module baud_rate_generator_frac
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DEF_INT  = DEFAULT_INT,
    parameter int unsigned DEF_FRAC = DEFAULT_FRAC
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_restart,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    output logic              o_div_ack,
    output logic              o_sample_tick,
    output logic              o_bit_tick
);

    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  int_q;
    logic [DIV_W-1:0]  shadow_int_q;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] shadow_frac_q;
    logic              long_q;
    logic              pending_q;
    logic              sample_tick_q;
    logic              bit_tick_q;
    logic              div_ack_q;

    logic [DIV_W-1:0]  last_cnt;
    logic [DIV_W-1:0]  int_clamped;
    logic [FRAC_W:0]   acc_sum;
    logic              period_end;
    logic              apply;
    logic              ovs_wrap;

    // A long period (carry from the previous end) runs one extra cycle.
    assign last_cnt = long_q ? int_q : int_q - 1'b1;

    // >= keeps the counter bounded if a smaller divisor lands while frozen mid-period.
    assign period_end  = i_enable && !i_restart && (cnt_q >= last_cnt);
    assign acc_sum     = {1'b0, acc_q} + {1'b0, frac_q};
    assign apply       = pending_q && (i_restart || period_end || !i_enable);
    assign int_clamped = (i_div_int < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : i_div_int;

    baud_ovs_counter #(
        .OVS (OVS)
    ) u_ovs_counter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (period_end),
        .i_clear   (i_restart),
        .o_wrap    (ovs_wrap)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            long_q        <= 1'b0;
            int_q         <= DIV_W'(DEF_INT);
            frac_q        <= FRAC_W'(DEF_FRAC);
            shadow_int_q  <= DIV_W'(DEF_INT);
            shadow_frac_q <= FRAC_W'(DEF_FRAC);
            pending_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            bit_tick_q    <= 1'b0;
            div_ack_q     <= 1'b0;
        end else begin
            sample_tick_q <= period_end;
            bit_tick_q    <= ovs_wrap;
            div_ack_q     <= apply;

            if (i_restart) begin
                cnt_q  <= '0;
                acc_q  <= '0;
                long_q <= 1'b0;
            end else if (period_end) begin
                cnt_q  <= '0;
                acc_q  <= acc_sum[FRAC_W-1:0];
                long_q <= acc_sum[FRAC_W];
            end else if (i_enable) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (apply) begin
                int_q  <= shadow_int_q;
                frac_q <= shadow_frac_q;
            end

            // A load on the apply edge refills the shadow and stays pending.
            if (i_div_load) begin
                shadow_int_q  <= int_clamped;
                shadow_frac_q <= i_div_frac;
                pending_q     <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign o_sample_tick = sample_tick_q;
    assign o_bit_tick    = bit_tick_q;
    assign o_div_ack     = div_ack_q;

endmodule
